// File: rtl/fir_decimating_output_stage_if.sv
// Sample/result handshake bundle between the FIR core, the decimating output stage
// and the audio sink.
interface fir_decimating_output_stage_if #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 2
);
  logic signed [WIDTH-1:0]  in;
  logic                     in_valid;
  logic signed [WIDTH-1:0]  out;
  logic                     out_valid;
  logic                     out_ready;
  logic [LOG2_DEPTH:0]      fifo_count;
  logic                     overflow;

  modport master (
    input  in, in_valid, out_ready,
    output out, out_valid, fifo_count, overflow
  );

  modport slave (
    output in, in_valid, out_ready,
    input  out, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/fir_decimating_output_stage.sv
// Block-averages groups of 2**LOG2_DECIM FIR samples with round-half-up and saturation,
// and queues the results in a small FIFO drained over valid/ready.
module fir_decimating_output_stage #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DECIM = 2,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  fir_decimating_output_stage_if.master bus
);
  localparam int DECIM = 1 << LOG2_DECIM;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int AW    = WIDTH + LOG2_DECIM;
  localparam int PW    = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int CW    = LOG2_DEPTH + 1;

  localparam logic signed [AW:0] RND  = (AW+1)'(DECIM / 2);
  localparam logic signed [AW:0] MAXV = {{(LOG2_DECIM+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(LOG2_DECIM+2){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW:0] v);
    logic signed [WIDTH-1:0] r;
    if (v > MAXV) begin
      r = MAXV[WIDTH-1:0];
    end else if (v < MINV) begin
      r = MINV[WIDTH-1:0];
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  logic signed [AW-1:0]    acc_r;
  logic [PW-1:0]           phase_r;
  logic signed [WIDTH-1:0] mem_r [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr_r;
  logic [LOG2_DEPTH-1:0]   rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic signed [WIDTH-1:0] out_r;
  logic                    out_valid_r;
  logic                    overflow_r;

  logic signed [AW-1:0]    in_ext_s;
  logic signed [AW-1:0]    sum_s;
  logic signed [AW:0]      rnd_sum_s;
  logic signed [WIDTH-1:0] res_s;
  logic                    last_s;
  logic                    do_pop_s;
  logic                    do_push_s;
  logic                    drop_s;
  logic [LOG2_DEPTH-1:0]   rd_nxt_s;
  logic [CW-1:0]           count_nxt_s;
  logic signed [WIDTH-1:0] head_nxt_s;

  // Group arithmetic, handshake decisions and next FIFO head
  always_comb begin
    in_ext_s    = AW'(bus.in);
    sum_s       = acc_r + in_ext_s;
    rnd_sum_s   = (AW+1)'(sum_s) + RND;
    res_s       = sat(rnd_sum_s >>> LOG2_DECIM);
    last_s      = bus.in_valid && (phase_r == PW'(DECIM - 1));
    do_pop_s    = (count_r != {CW{1'b0}}) && bus.out_ready;
    do_push_s   = last_s && ((count_r != CW'(DEPTH)) || do_pop_s);
    drop_s      = last_s && (count_r == CW'(DEPTH)) && !do_pop_s;
    rd_nxt_s    = do_pop_s ? (rd_ptr_r + LOG2_DEPTH'(1)) : rd_ptr_r;
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    // A push landing on the new head slot means the queue was empty after any pop
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = {WIDTH{1'b0}};
    end else if (do_push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = res_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Accumulator and phase counter across one decimation group
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r   <= {AW{1'b0}};
      phase_r <= {PW{1'b0}};
    end else if (last_s) begin
      acc_r   <= {AW{1'b0}};
      phase_r <= {PW{1'b0}};
    end else if (bus.in_valid) begin
      acc_r   <= sum_s;
      phase_r <= phase_r + PW'(1);
    end else begin
      acc_r   <= acc_r;
      phase_r <= phase_r;
    end
  end

  // Result FIFO storage, pointers, registered head and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r    <= {LOG2_DEPTH{1'b0}};
      rd_ptr_r    <= {LOG2_DEPTH{1'b0}};
      count_r     <= {CW{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= res_s;
        wr_ptr_r        <= wr_ptr_r + LOG2_DEPTH'(1);
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      out_r       <= head_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      overflow_r  <= overflow_r | drop_s;
    end
  end

  assign bus.out        = out_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.fifo_count = count_r;
  assign bus.overflow   = overflow_r;

endmodule
